rf_writeback_ctrl: RTL and testbench

// - Write-side owner of the register file: arbitrates ALU and LSU results onto the single RF write port (wr_addr0/wr_din0/we0).
// - Holds a pending-write scoreboard (one bit per architectural register) and stalls issue on WAW.
// - Gives decode a busy status for both source operands, so operands are only read once committed.
// - Sits between the execute/LSU stages and regfile; decode drives the issue and query ports.

---
 rtl/rf_writeback_ctrl_pkg.sv | 19 +
 rtl/rf_writeback_ctrl_rr_arb2.sv | 47 ++++
 rtl/rf_writeback_ctrl.sv | 145 ++++++++++++++
 tb/tb_rf_writeback_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_writeback_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg
// Shared definitions for the register-file writeback controller.
//   RF_WIDTH / RF_DEPTH : default data width and register count
//   RF_AW               : register address width derived from RF_DEPTH
//   src_e               : result source identifier (ALU = SRC_A, LSU = SRC_B)
// ---------------------------------------------------------------------------
package rf_pkg;

  localparam int RF_WIDTH = 32;
  localparam int RF_DEPTH = 32;
  localparam int RF_AW    = $clog2(RF_DEPTH);

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

endpackage

// File: rtl/rf_writeback_ctrl_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin arbiter. When both requesters are active, the
// one that was not granted last time wins. The remembered winner (rr_last)
// only moves when a grant is actually issued.
// Ports:
//   clk, rst      clock, synchronous active-high reset (rr_last -> SRC_A)
//   req[1:0]      bit 0 = source A, bit 1 = source B
//   gnt[1:0]      one-hot grant, combinational from req and rr_last
//   rr_last       current arbiter state (last granted source)
// ---------------------------------------------------------------------------
module rr_arb2
  import rf_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output src_e       rr_last
);

  src_e rr_last_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last <= SRC_A;
    end else begin
      rr_last <= rr_last_nxt;
    end
  end

  always_comb begin
    gnt         = 2'b00;
    rr_last_nxt = rr_last;
    if (req == 2'b11) begin
      gnt = (rr_last == SRC_A) ? 2'b10 : 2'b01;
    end else begin
      gnt = req;
    end
    if (gnt[0]) begin
      rr_last_nxt = SRC_A;
    end else if (gnt[1]) begin
      rr_last_nxt = SRC_B;
    end
  end

endmodule

// File: rtl/rf_writeback_ctrl.sv
// ---------------------------------------------------------------------------
// rf_writeback_ctrl
// Write-side owner of the register file. Arbitrates ALU (A) and LSU (B)
// results onto the single RF write port, keeps a one-bit-per-register
// pending-write scoreboard, stalls issue on WAW and reports operand busy
// status to decode.
//
// Handshake: a transfer happens on a cycle where valid & ready are both 1.
// ready is combinational and never asserted without its valid; at most one
// of a_ready / b_ready is high in any cycle.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   iss_valid/iss_rd/iss_ready  issue port (iss_ready=0 is a WAW stall)
//   a_valid/a_ready/a_rd/a_data ALU result handshake
//   b_valid/b_ready/b_rd/b_data LSU result handshake
//   wr_addr0/wr_din0/we0     registered RF write port
//   q_addr0/1, q_busy0/1     operand busy queries (combinational)
//   err_unexp                sticky: result accepted for a non-pending rd
//
// Build option RF_WB_BYPASS_EN: adds byp_data0/1. A query matching the
// register being written this cycle reports not-busy and returns the
// in-flight data, one cycle ahead of the RF commit.
// ---------------------------------------------------------------------------
module rf_writeback_ctrl
  import rf_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH,
  parameter int DEPTH = RF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_rd,
  output logic             iss_ready,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [AW-1:0]    a_rd,
  input  logic [WIDTH-1:0] a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [AW-1:0]    b_rd,
  input  logic [WIDTH-1:0] b_data,
  output logic [AW-1:0]    wr_addr0,
  output logic [WIDTH-1:0] wr_din0,
  output logic             we0,
  input  logic [AW-1:0]    q_addr0,
  input  logic [AW-1:0]    q_addr1,
  output logic             q_busy0,
  output logic             q_busy1,
  output logic             err_unexp
`ifdef RF_WB_BYPASS_EN
  ,
  output logic [WIDTH-1:0] byp_data0,
  output logic [WIDTH-1:0] byp_data1
`endif
);

  logic [DEPTH-1:0] pending;
  logic [DEPTH-1:0] pending_nxt;
  logic [1:0]       gnt;
  src_e             rr_last;
  logic             acc;
  logic [AW-1:0]    acc_rd;
  logic [WIDTH-1:0] acc_data;
  logic             iss_fire;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({b_valid, a_valid}),
    .gnt     (gnt),
    .rr_last (rr_last)
  );

  assign a_ready  = gnt[0];
  assign b_ready  = gnt[1];
  assign acc      = |gnt;
  assign acc_rd   = gnt[1] ? b_rd   : a_rd;
  assign acc_data = gnt[1] ? b_data : a_data;

  // x0 never stalls; any other rd stalls while a write to it is outstanding.
  assign iss_ready = (iss_rd == '0) | ~pending[iss_rd];
  assign iss_fire  = iss_valid & iss_ready;

  // Clear follows the registered write (commit edge); set follows issue.
  // Both target distinct registers because issue stalls while pending.
  always_comb begin
    pending_nxt = pending;
    if (we0) begin
      pending_nxt[wr_addr0] = 1'b0;
    end
    if (iss_fire && (iss_rd != '0)) begin
      pending_nxt[iss_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending   <= '0;
      we0       <= 1'b0;
      wr_addr0  <= '0;
      wr_din0   <= '0;
      err_unexp <= 1'b0;
    end else begin
      pending <= pending_nxt;
      if (acc) begin
        wr_addr0 <= acc_rd;
        wr_din0  <= acc_data;
        // Results for x0 are consumed but never written.
        we0      <= (acc_rd != '0);
        if ((acc_rd != '0) && !pending[acc_rd]) begin
          err_unexp <= 1'b1;
        end
      end else begin
        we0 <= 1'b0;
      end
    end
  end

`ifdef RF_WB_BYPASS_EN
  logic hit0;
  logic hit1;

  always_comb begin
    hit0      = we0 & (wr_addr0 == q_addr0) & (q_addr0 != '0);
    hit1      = we0 & (wr_addr1_unused_guard(q_addr1)) & (q_addr1 != '0);
    byp_data0 = hit0 ? wr_din0 : '0;
    byp_data1 = hit1 ? wr_din0 : '0;
    q_busy0   = (q_addr0 != '0) & pending[q_addr0] & ~hit0;
    q_busy1   = (q_addr1 != '0) & pending[q_addr1] & ~hit1;
  end

  function automatic logic wr_addr1_unused_guard(input logic [AW-1:0] q);
    return (wr_addr0 == q);
  endfunction
`else
  always_comb begin
    q_busy0 = (q_addr0 != '0) & pending[q_addr0];
    q_busy1 = (q_addr1 != '0) & pending[q_addr1];
  end
`endif

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rf_writeback_ctrl
// Directed scenarios followed by randomized traffic, checked against a
// behavioural model of the scoreboard, arbitration and write port.
// ---------------------------------------------------------------------------
module tb_rf_writeback_ctrl;

  localparam int W  = 32;
  localparam int D  = 32;
  localparam int AW = 5;
`ifdef RF_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          iss_valid;
  logic [AW-1:0] iss_rd;
  logic          iss_ready;
  logic          a_valid, a_ready, b_valid, b_ready;
  logic [AW-1:0] a_rd, b_rd;
  logic [W-1:0]  a_data, b_data;
  logic [AW-1:0] wr_addr0;
  logic [W-1:0]  wr_din0;
  logic          we0;
  logic [AW-1:0] q_addr0, q_addr1;
  logic          q_busy0, q_busy1;
  logic          err_unexp;
`ifdef RF_WB_BYPASS_EN
  logic [W-1:0]  byp_data0, byp_data1;
`endif

  rf_writeback_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_rd      (a_rd),
    .a_data    (a_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_rd      (b_rd),
    .b_data    (b_data),
    .wr_addr0  (wr_addr0),
    .wr_din0   (wr_din0),
    .we0       (we0),
    .q_addr0   (q_addr0),
    .q_addr1   (q_addr1),
    .q_busy0   (q_busy0),
    .q_busy1   (q_busy1),
    .err_unexp (err_unexp)
`ifdef RF_WB_BYPASS_EN
    ,
    .byp_data0 (byp_data0),
    .byp_data1 (byp_data1)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit            pend[D];     // register has an outstanding write
  bit            m_last_b;    // last granted source was the LSU
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [W-1:0]  m_din;
  bit            m_err;
  bit            e_a, e_b, e_iss;

  // scoreboard of expected RF writes {addr, data}
  logic [AW+W-1:0] exp_q[$];

  int tests_run;
  int tests_failed;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_busy(input logic [AW-1:0] q);
    bit in_flight;
    in_flight = BYP && m_we && (m_addr == q);
    return (q != 0) && pend[q] && !in_flight;
  endfunction

  function automatic logic [W-1:0] exp_byp(input logic [AW-1:0] q);
    return (BYP && m_we && (m_addr == q) && (q != 0)) ? m_din : '0;
  endfunction

  task automatic model_edge();
    logic [AW-1:0] rd;
    logic [W-1:0]  data;
    bit            we_nxt;
    logic [AW-1:0] commit_addr;
    bit            commit;
    if (rst) begin
      foreach (pend[i]) pend[i] = 1'b0;
      m_last_b = 1'b0;
      m_we = 1'b0;
      m_addr = '0;
      m_din = '0;
      m_err = 1'b0;
      exp_q.delete();
    end else begin
      commit = m_we;
      commit_addr = m_addr;
      we_nxt = 1'b0;
      if (e_a || e_b) begin
        rd   = e_b ? b_rd : a_rd;
        data = e_b ? b_data : a_data;
        if (rd != 0 && !pend[rd]) m_err = 1'b1;
        m_last_b = e_b;
        m_addr = rd;
        m_din = data;
        we_nxt = (rd != 0);
        if (rd != 0) exp_q.push_back({rd, data});
      end
      if (commit) pend[commit_addr] = 1'b0;
      if (iss_valid && e_iss && iss_rd != 0) pend[iss_rd] = 1'b1;
      m_we = we_nxt;
    end
  endtask

  // One clock: check combinational outputs, take the edge, check registers.
  task automatic cyc();
    logic [AW+W-1:0] item;
    #1;
    e_a   = a_valid && (!b_valid || m_last_b);
    e_b   = b_valid && (!a_valid || !m_last_b);
    e_iss = (iss_rd == 0) || !pend[iss_rd];
    check("a_ready", a_ready, e_a);
    check("b_ready", b_ready, e_b);
    check("iss_ready", iss_ready, e_iss);
    check("q_busy0", q_busy0, exp_busy(q_addr0));
    check("q_busy1", q_busy1, exp_busy(q_addr1));
`ifdef RF_WB_BYPASS_EN
    check("byp_data0", byp_data0, exp_byp(q_addr0));
    check("byp_data1", byp_data1, exp_byp(q_addr1));
`endif
    @(posedge clk);
    model_edge();
    #1;
    check("we0", we0, m_we);
    check("wr_addr0", wr_addr0, m_addr);
    check("wr_din0", wr_din0, m_din);
    check("err_unexp", err_unexp, m_err);
    if (we0) begin
      if (exp_q.size() == 0) begin
        check("commit_unexpected", we0, 1'b0);
      end else begin
        item = exp_q.pop_front();
        check("commit_sb", {wr_addr0, wr_din0}, item);
      end
    end
  endtask

  task automatic idle_inputs();
    iss_valid = 0; iss_rd = 0;
    a_valid = 0; a_rd = 0; a_data = 0;
    b_valid = 0; b_rd = 0; b_data = 0;
    q_addr0 = 0; q_addr1 = 0;
  endtask

  function automatic logic [AW-1:0] pick_rd();
    logic [AW-1:0] r;
    if ($urandom_range(0, 3) != 0) begin
      for (int t = 0; t < 8; t++) begin
        r = AW'($urandom_range(1, D - 1));
        if (pend[r]) return r;
      end
    end
    return AW'($urandom_range(0, D - 1));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    bit start_b;
    tests_run = 0;
    tests_failed = 0;
    idle_inputs();
    rst = 1;
    cyc();
    cyc();
    rst = 0;
    check("reset_we0", we0, 1'b0);
    check("reset_addr", wr_addr0, '0);
    check("reset_din", wr_din0, '0);
    check("reset_err", err_unexp, 1'b0);

    // Issue rd=5, then ALU result for it.
    iss_valid = 1; iss_rd = 5; q_addr0 = 5;
    cyc();
    iss_valid = 0;
    a_valid = 1; a_rd = 5; a_data = 32'hDEADBEEF;
    #1 check("t1_busy_pre", q_busy0, 1'b1);
    cyc();
    check("t1_we0", we0, 1'b1);
    check("t1_addr", wr_addr0, 5);
    check("t1_din", wr_din0, 32'hDEADBEEF);
    a_valid = 0;
    #1 check("t1_busy_we", q_busy0, BYP ? 1'b0 : 1'b1);
    cyc();
    #1 check("t1_busy_after", q_busy0, 1'b0);
    cyc();

    // Result for x0, then for a non-pending register.
    a_valid = 1; a_rd = 0; a_data = 32'hFFFFFFFF;
    #1 check("t2_x0_ready", a_ready, 1'b1);
    cyc();
    check("t2_x0_we0", we0, 1'b0);
    check("t2_x0_err", err_unexp, 1'b0);
    a_rd = 9; a_data = 32'h99;
    cyc();
    check("t2_r9_we0", we0, 1'b1);
    check("t2_r9_err", err_unexp, 1'b1);
    a_valid = 0;
    cyc();
    cyc();
    check("t2_err_sticky", err_unexp, 1'b1);

    // Both sources valid for 3 cycles: grants alternate.
    iss_valid = 1; iss_rd = 3;
    cyc();
    iss_rd = 4;
    cyc();
    iss_valid = 0;
    a_valid = 1; a_rd = 3; a_data = 32'h11;
    b_valid = 1; b_rd = 4; b_data = 32'h22;
    start_b = !m_last_b;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t3_alt_b", b_ready, start_b ^ i[0]);
      check("t3_alt_a", a_ready, !(start_b ^ i[0]));
      cyc();
    end
    a_valid = 0; b_valid = 0;
    cyc();
    cyc();

    // Back-to-back issue of rd=7: second stalls until the commit edge.
    iss_valid = 1; iss_rd = 7;
    cyc();
    #1 check("t4_stall0", iss_ready, 1'b0);
    cyc();
    a_valid = 1; a_rd = 7; a_data = $urandom;
    #1 check("t4_stall1", iss_ready, 1'b0);
    cyc();
    a_valid = 0;
    #1 check("t4_stall_we", iss_ready, 1'b0);
    cyc();
    #1 check("t4_accept", iss_ready, 1'b1);
    cyc();
    iss_valid = 0;
    cyc();

    // Query in the write cycle of rd=6.
    iss_valid = 1; iss_rd = 6;
    cyc();
    iss_valid = 0;
    a_valid = 1; a_rd = 6; a_data = 32'h1234;
    cyc();
    a_valid = 0; q_addr1 = 6;
    #1 check("t5_busy1", q_busy1, BYP ? 1'b0 : 1'b1);
`ifdef RF_WB_BYPASS_EN
    check("t5_byp1", byp_data1, 32'h1234);
`endif
    cyc();

    // Reset while a write for rd=12 is in flight.
    iss_valid = 1; iss_rd = 12;
    cyc();
    iss_valid = 0;
    a_valid = 1; a_rd = 12; a_data = 32'hC0FFEE;
    cyc();
    check("t6_we_before", we0, 1'b1);
    a_valid = 0; rst = 1; q_addr0 = 12; q_addr1 = 5;
    cyc();
    rst = 0;
    check("t6_we0", we0, 1'b0);
    check("t6_err", err_unexp, 1'b0);
    #1;
    check("t6_busy0", q_busy0, 1'b0);
    check("t6_busy1", q_busy1, 1'b0);
    cyc();

    // Randomized traffic; pending results are held until accepted.
    idle_inputs();
    e_a = 0; e_b = 0;
    for (int n = 0; n < 400; n++) begin
      if (!a_valid || e_a) begin
        a_valid = ($urandom_range(0, 2) != 0);
        a_rd = pick_rd();
        a_data = $urandom;
      end
      if (!b_valid || e_b) begin
        b_valid = ($urandom_range(0, 2) != 0);
        b_rd = pick_rd();
        b_data = $urandom;
      end
      iss_valid = $urandom_range(0, 1);
      iss_rd = AW'($urandom_range(0, D - 1));
      q_addr0 = ($urandom_range(0, 1) != 0) ? m_addr : AW'($urandom_range(0, D - 1));
      q_addr1 = AW'($urandom_range(0, D - 1));
      rst = ($urandom_range(0, 99) == 0);
      cyc();
    end
    rst = 0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
